// File: rtl/ecliptic_fpu_sequencer.sv
// Single-issue front end for the ecliptic float sub-units: accepts one op,
// drives the chosen unit's req/ack handshake and returns its result with a tag.
module ecliptic_fpu_sequencer #(
    parameter int NUNIT   = 5,
    parameter int TIMEOUT = 64,
    parameter int TAGW    = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_unit,
    input  logic [2:0]            in_subop,
    input  logic [31:0]           in_src1,
    input  logic [31:0]           in_src2,
    input  logic                  in_unsigned,
    input  logic [TAGW-1:0]       in_tag,
    output logic [NUNIT-1:0]      unit_req,
    input  logic [NUNIT-1:0]      unit_ack,
    input  logic [NUNIT*32-1:0]   unit_res,
    input  logic [NUNIT*5-1:0]    unit_flags,
    output logic [31:0]           op_src1,
    output logic [31:0]           op_src2,
    output logic [2:0]            op_subop,
    output logic                  op_unsigned,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_res,
    output logic [4:0]            out_flags,
    output logic                  out_err,
    output logic [TAGW-1:0]       out_tag
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} SeqState;

    SeqState     state;
    SeqState     nextState;
    logic [2:0]  unitIdx;
    logic [31:0] wdCount;
    logic        accept;
    logic        goodIdx;
    logic        timeoutHit;
    logic        selAck;
    logic [31:0] selRes;
    logic [4:0]  selFlags;

    assign accept     = in_valid && in_ready;
    assign goodIdx    = {29'd0, in_unit} < 32'(NUNIT);
    assign timeoutHit = (TIMEOUT != 0) && (wdCount == 32'(TIMEOUT - 1));

    // Pick out the ack/result/flags of the unit currently being served.
    always_comb begin
        selAck   = 1'b0;
        selRes   = '0;
        selFlags = '0;
        for (int i = 0; i < NUNIT; i++) begin
            if (unitIdx == 3'(i)) begin
                selAck   = unit_ack[i];
                selRes   = unit_res[32*i +: 32];
                selFlags = unit_flags[5*i +: 5];
            end
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = goodIdx ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (selAck || timeoutHit) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    if (in_valid) begin
                        nextState = goodIdx ? ISSUE : RESP;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // req is decoded from registered state, so an async reset drops it at once.
    always_comb begin
        in_ready  = (state == IDLE) || ((state == RESP) && out_ready);
        out_valid = (state == RESP);
        unit_req  = '0;
        for (int i = 0; i < NUNIT; i++) begin
            unit_req[i] = (state == ISSUE) && (unitIdx == 3'(i));
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            op_src1     <= '0;
            op_src2     <= '0;
            op_subop    <= '0;
            op_unsigned <= 1'b0;
            out_tag     <= '0;
            out_res     <= '0;
            out_flags   <= '0;
            out_err     <= 1'b0;
            unitIdx     <= '0;
            wdCount     <= '0;
        end else begin
            if (accept) begin
                op_src1     <= in_src1;
                op_src2     <= in_src2;
                op_subop    <= in_subop;
                op_unsigned <= in_unsigned;
                out_tag     <= in_tag;
                unitIdx     <= in_unit;
                wdCount     <= '0;
                if (!goodIdx) begin
                    out_res   <= '0;
                    out_flags <= '0;
                    out_err   <= 1'b1;
                end
            end else if (state == ISSUE) begin
                wdCount <= wdCount + 32'd1;
                if (selAck) begin
                    out_res   <= selRes;
                    out_flags <= selFlags;
                    out_err   <= 1'b0;
                end else if (timeoutHit) begin
                    out_res   <= '0;
                    out_flags <= '0;
                    out_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ecliptic_fpu_sequencer.md
Name: ecliptic_fpu_sequencer

Overview:
Front-end controller for the ecliptic float sub-units: bitoperation, classification, comparison, converter_to_float, converter_to_word.
- Accepts one float instruction at a time over a valid/ready handshake and latches its operands.
- Drives the selected sub-unit's req/ack handshake and captures the result and exception flags.
- Returns the result over a valid/ready response channel, with a watchdog timeout per operation.
- Sits between the core's execute stage and the sub-unit bank.

Parameters:
- NUNIT, 5, number of attached sub-units; unit index 0..NUNIT-1.
- TIMEOUT, 64, max cycles waiting for ack; 0 disables the watchdog.
- TAGW, 4, width of the requester tag echoed with the response.

Ports:
- clk  in  1  clock; all state on rising edge.
- nrst  in  1  reset, asynchronous, active-high (asserted = reset, despite name).
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- in_unit  in  3  target sub-unit index.
- in_subop  in  3  sub-unit op code, passed through.
- in_src1  in  32  operand 1.
- in_src2  in  32  operand 2.
- in_unsigned  in  1  unsigned flag for converters.
- in_tag  in  TAGW  requester tag.
- unit_req  out  NUNIT  one-hot req to sub-units.
- unit_ack  in  NUNIT  ack from sub-units.
- unit_res  in  NUNIT*32  results, unit i at [32i+31:32i].
- unit_flags  in  NUNIT*5  fflags {NV,DZ,OF,UF,NX}, unit i at [5i+4:5i].
- op_src1, op_src2  out  32 each  latched operands broadcast to all units.
- op_subop  out  3  latched sub-op.
- op_unsigned  out  1  latched unsigned flag.
- out_valid  out  1  response valid.
- out_ready  in  1  response accepted when out_valid&&out_ready.
- out_res  out  32  result.
- out_flags  out  5  exception flags.
- out_err  out  1  1 = bad unit index or timeout.
- out_tag  out  TAGW  echoed tag.

Behaviour:
- Reset: state IDLE; unit_req=0, out_valid=0, out_res=0, out_flags=0, out_err=0, out_tag=0, op_* =0, watchdog count=0. Reset mid-operation aborts it: req drops immediately (async), no response is produced.
- in_ready = (state==IDLE) || (state==RESP && out_ready), combinational.
- FSM states:
  - IDLE: on accept, latch op_*, tag and unit index. If unit index < NUNIT, go to ISSUE; otherwise go to RESP with out_res=0, out_flags=0, out_err=1.
  - ISSUE: unit_req[idx]=1 (registered, one-hot), watchdog counts up each cycle.
    - unit_ack[idx]=1: capture the res/flags slice, out_err=0, unit_req->0, go to RESP.
    - Otherwise, if TIMEOUT!=0 and count==TIMEOUT-1: out_res=0, out_flags=0, out_err=1, unit_req->0, go to RESP.
    - Ack and timeout in the same cycle: ack wins.
    - Acks on unselected units are ignored.
    - Acks in IDLE or RESP are ignored.
  - RESP: out_valid=1; outputs are stable until out_ready.
    - On handshake with a new accept in the same cycle: load the new op and go to ISSUE, or stay in RESP for a bad index.
    - On handshake without an accept: go to IDLE, out_valid->0.
- Latency: accept at edge N; unit_req high in cycle N+1; ack sampled at edge N+1+k; out_valid high from N+2+k. Minimum 2 cycles when the unit acks in its first req cycle.
- Throughput: one op per (k+2) cycles; the back-to-back path through RESP removes the IDLE bubble.
- Watchdog clears to 0 on every ISSUE entry.
- op_* stay stable for the whole ISSUE period.

Test Plan:
- Accept unit=0 (bitop), src1=0x3f800000, src2=0xcf800000; unit 0 acks in its first req cycle with res=0x4f800000 -> unit_req=5'b00001 exactly one cycle; out_valid 2 cycles after accept; out_res=0x4f800000, out_err=0, tag echoed.
- Accept unit=4 (cvt.w), src1=0x40400000; ack after 3 cycles with res=3, flags=0 -> unit_req=5'b10000 held 4 cycles; out_res=3. Pulse unit_ack[2] mid-wait -> ignored.
- Accept unit=2 (cmp), src1=0x7f800001; ack with flags=5'b10000 -> out_flags=5'b10000 (NV). Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- TIMEOUT=8, unit 1 never acks -> unit_req[1] high exactly 8 cycles, then out_err=1, out_res=0. Repeat with ack on cycle 8 -> normal result, out_err=0.
- Accept unit=6 -> no unit_req pulse; out_valid next cycle, out_err=1.
- Back-to-back: out_ready=1 and in_valid=1 during RESP -> new op accepted the same cycle, new unit_req next cycle. Separately, assert nrst during ISSUE -> unit_req=0 and out_valid=0 immediately; after release, in_ready=1.
